pool_ofm_writer: RTL and testbench
==================================

Name: pool_ofm_writer

Overview:
- Consumer end of the max-pooling output interface: accepts the `ready_write` strobe and signed 8-bit `ifm_output` value from the pooling stage.
- Packs pooled values into memory words, LSB byte first, with the last word of a layer possibly partial.
- Buffers words in a small FIFO and writes them to the output feature-map memory through a valid/ready write port with sequential word addresses.
- Sits between the pooling stage and the OFM SRAM; the layer controller drives it with a start pulse and receives a done pulse.

Parameters:
- DATA_WIDTH, 8, width of one pooled value.
- WORD_WIDTH, 32, memory word width; must be a multiple of DATA_WIDTH; BYTES = WORD_WIDTH/DATA_WIDTH.
- ADDR_WIDTH, 16, word-address width; also the width of the output count.
- FIFO_DEPTH, 4, word FIFO entries; must be a power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; latches base_addr and num_outputs.
- base_addr  in  ADDR_WIDTH  first word address for the layer.
- num_outputs  in  ADDR_WIDTH  total pooled values expected for the layer.
- ready_write  in  1  pooled value valid this cycle.
- ifm_output  in  DATA_WIDTH  signed pooled value.
- busy  out  1  high from the start pulse until done.
- done  out  1  one-cycle pulse after the last word is accepted by memory.
- overflow  out  1  sticky; a value was dropped.
- mem_wr_en  out  1  write request.
- mem_wr_ready  in  1  memory accepts the request this cycle.
- mem_addr  out  ADDR_WIDTH  word address.
- mem_wdata  out  WORD_WIDTH  packed data.
- mem_byte_en  out  BYTES  lane enables.

Behaviour:
- Reset: rst is synchronous and active-high and takes effect at any state, including mid-layer. It clears:
  - all outputs to 0;
  - the FIFO to empty;
  - the packer, counters and address;
  - the FSM to IDLE.
- FSM states and transitions:
  - IDLE: wait for start. On start, go to COLLECT and set busy the next cycle. If num_outputs == 0, go directly to DONE instead.
  - COLLECT: pack incoming values. When the received count equals num_outputs, go to FLUSH.
  - FLUSH: stay until the FIFO is empty and no write is outstanding, then go to DONE.
  - DONE: assert done for exactly one cycle, clear busy, return to IDLE.
- Ignored inputs:
  - start while busy is ignored.
  - ready_write outside COLLECT is ignored (no count, no overflow).
- Packing:
  - Value k of a word goes to bits [k*DATA_WIDTH +: DATA_WIDTH] and sets byte_en bit k.
  - A word is pushed into the FIFO in the same cycle its BYTES-th value arrives.
  - A word is also pushed when the layer's last value arrives, even if partial. A partial word has unused lanes zeroed and their byte_en bits cleared.
- FIFO:
  - Push and pop in the same cycle are allowed, including when the FIFO is full.
  - If a push is needed while the FIFO is full and no pop happens that cycle, the completing value is dropped and overflow is set.
  - A dropped value still counts toward num_outputs.
  - The packer restarts empty after a word completes, whether pushed or dropped.
- Memory side:
  - mem_wr_en/addr/wdata/byte_en are registered and present the FIFO head.
  - mem_wr_en rises the cycle after a push into an empty FIFO (latency 1).
  - A transfer occurs when mem_wr_en && mem_wr_ready. mem_addr then increments by 1 and the next head is presented on the next cycle without a bubble.
  - While mem_wr_en is high and mem_wr_ready is low, all mem_* outputs hold stable.
- Address arithmetic:
  - mem_addr wraps modulo 2^ADDR_WIDTH with no error.
  - Word count = ceil(num_outputs/BYTES).
- overflow clears only on rst or on an accepted start.

Optional Feature:
- Macro: OFM_RELU_EN.
- When defined: a value with its sign bit set is replaced by 0 before packing; count and byte_en behaviour are unchanged.
- When undefined: values are packed unmodified as two's complement.

Test Plan:
- Four-value layer:
  - Stimulus: start with base_addr=0x0010, num_outputs=4; ready_write on 4 consecutive cycles with values 0x11, 0x22, 0x33, 0x44; mem_wr_ready=1.
  - Required: one write to addr 0x0010 with wdata=0x44332211 and byte_en=0xF; done pulses once; busy falls with it.
- Partial last word:
  - Stimulus: num_outputs=6 with values 0x01 to 0x06.
  - Required: first write wdata=0x04030201, byte_en=0xF, addr=base; second write wdata=0x00000605, byte_en=0x3, addr=base+1.
- Backpressure and overflow:
  - Stimulus: mem_wr_ready held 0; num_outputs=24 streamed continuously.
  - Required: 4 words buffered, the 5th word's completing value dropped; overflow=1 and stays 1; mem_* stable while stalled. After mem_wr_ready=1, writes drain in order and done still pulses.
- Ignored inputs and zero-length layer:
  - Stimulus: ready_write in IDLE; start during busy; start with num_outputs=0.
  - Required: no writes, counts unaffected; done pulses 2 cycles after start with no mem_wr_en.
- Reset mid-layer:
  - Stimulus: rst asserted after 5 of 8 values, with a word pending in the FIFO.
  - Required: the next cycle has all outputs 0 and the FIFO empty. A new start then behaves like a fresh layer with addr=base.
- Negative values:
  - Stimulus: values 0x80, 0x7F, 0xFF, 0x01.
  - Required: wdata=0x01FF7F80 with OFM_RELU_EN undefined; wdata=0x01007F00 with it defined.

Source files
------------

// File: rtl/pool_ofm_writer.sv
// Packs pooled values into memory words and streams them to the OFM memory through a small word FIFO.
// Optional macro OFM_RELU_EN clamps negative values to zero before packing.
module pool_ofm_writer #(
   parameter int DATA_WIDTH = 8,
   parameter int WORD_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int FIFO_DEPTH = 4,
   localparam int BYTES     = WORD_WIDTH / DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH-1:0] num_outputs,
   input  logic                  ready_write,
   input  logic [DATA_WIDTH-1:0] ifm_output,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic                  mem_wr_en,
   input  logic                  mem_wr_ready,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [WORD_WIDTH-1:0] mem_wdata,
   output logic [BYTES-1:0]      mem_byte_en
);

   localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FLUSH, S_DONE} state_t;

   state_t state_reg, state_next;

   logic [ADDR_WIDTH-1:0] num_reg, recv_cnt_reg;
   logic [LANE_W-1:0]     lane_reg;
   logic [WORD_WIDTH-1:0] pack_data_reg;
   logic [BYTES-1:0]      pack_be_reg;
   logic                  busy_reg, done_reg, overflow_reg;

   logic [WORD_WIDTH-1:0] fifo_data [FIFO_DEPTH];
   logic [BYTES-1:0]      fifo_be   [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
   logic [PTR_W:0]        count_reg, count_next, remaining;

   logic                  mem_wr_en_reg;
   logic [ADDR_WIDTH-1:0] mem_addr_reg;
   logic [WORD_WIDTH-1:0] mem_wdata_reg;
   logic [BYTES-1:0]      mem_be_reg;

   logic [DATA_WIDTH-1:0] value_in;
   logic [WORD_WIDTH-1:0] word_data, head_data;
   logic [BYTES-1:0]      word_be, head_be;
   logic [PTR_W-1:0]      head_ptr;
   logic start_ok, accept_val, last_val, lane_last, word_complete;
   logic pop, push, drop, fifo_full;

`ifdef OFM_RELU_EN
   assign value_in = ifm_output[DATA_WIDTH-1] ? '0 : ifm_output;
`else
   assign value_in = ifm_output;
`endif

   assign start_ok      = (state_reg == S_IDLE) && start;
   assign accept_val    = (state_reg == S_COLLECT) && ready_write;
   assign last_val      = accept_val && ((recv_cnt_reg + ADDR_WIDTH'(1)) == num_reg);
   assign lane_last     = (lane_reg == LANE_W'(BYTES - 1));
   assign word_complete = accept_val && (lane_last || last_val);
   assign pop           = mem_wr_en_reg && mem_wr_ready;
   assign fifo_full     = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
   assign push          = word_complete && (!fifo_full || pop);
   assign drop          = word_complete && !push;

   // Merge the incoming value into its lane; lanes above it are still zero in the packer.
   generate
      for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
         assign word_data[gi*DATA_WIDTH +: DATA_WIDTH] =
            (lane_reg == LANE_W'(gi)) ? value_in : pack_data_reg[gi*DATA_WIDTH +: DATA_WIDTH];
         assign word_be[gi] = (lane_reg == LANE_W'(gi)) | pack_be_reg[gi];
      end
   endgenerate

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + (PTR_W+1)'(1);
         2'b01:   count_next = count_reg - (PTR_W+1)'(1);
         default: count_next = count_reg;
      endcase
   end

   // Head presented next cycle: when the FIFO would otherwise be empty, it is the word being pushed.
   assign remaining = count_reg - (PTR_W+1)'(pop);
   assign head_ptr  = rd_ptr_reg + PTR_W'(pop);
   assign head_data = (remaining == '0) ? word_data : fifo_data[head_ptr];
   assign head_be   = (remaining == '0) ? word_be   : fifo_be[head_ptr];

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:    if (start) state_next = (num_outputs == '0) ? S_DONE : S_COLLECT;
         S_COLLECT: if (last_val) state_next = S_FLUSH;
         S_FLUSH:   if ((count_reg == '0) && !mem_wr_en_reg) state_next = S_DONE;
         S_DONE:    state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         num_reg       <= '0;
         recv_cnt_reg  <= '0;
         lane_reg      <= '0;
         pack_data_reg <= '0;
         pack_be_reg   <= '0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         overflow_reg  <= 1'b0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         mem_wr_en_reg <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         mem_be_reg    <= '0;
      end else begin
         state_reg <= state_next;
         done_reg  <= (state_reg == S_DONE);
         if (start_ok)                  busy_reg <= 1'b1;
         else if (state_reg == S_DONE)  busy_reg <= 1'b0;
         if (start_ok)   overflow_reg <= 1'b0;
         else if (drop)  overflow_reg <= 1'b1;

         if (start_ok) begin
            num_reg      <= num_outputs;
            recv_cnt_reg <= '0;
         end else if (accept_val) begin
            recv_cnt_reg <= recv_cnt_reg + ADDR_WIDTH'(1);
         end

         if (start_ok || word_complete) begin
            lane_reg      <= '0;
            pack_data_reg <= '0;
            pack_be_reg   <= '0;
         end else if (accept_val) begin
            lane_reg      <= lane_reg + LANE_W'(1);
            pack_data_reg <= word_data;
            pack_be_reg   <= word_be;
         end

         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         count_reg <= count_next;

         mem_wr_en_reg <= (count_next != '0);
         mem_wdata_reg <= (count_next != '0) ? head_data : '0;
         mem_be_reg    <= (count_next != '0) ? head_be : '0;
         if (start_ok) mem_addr_reg <= base_addr;
         else if (pop) mem_addr_reg <= mem_addr_reg + ADDR_WIDTH'(1);
      end
   end

   // Storage array carries no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr_reg] <= word_data;
         fifo_be[wr_ptr_reg]   <= word_be;
      end
   end

   assign busy        = busy_reg;
   assign done        = done_reg;
   assign overflow    = overflow_reg;
   assign mem_wr_en   = mem_wr_en_reg;
   assign mem_addr    = mem_addr_reg;
   assign mem_wdata   = mem_wdata_reg;
   assign mem_byte_en = mem_be_reg;

endmodule

// File: tb/tb_pool_ofm_writer.sv
// Directed bench for pool_ofm_writer: layers, partial words, backpressure/overflow, ignored inputs, reset, sign handling.
module tb_pool_ofm_writer;
   localparam int DW = 8;
   localparam int WW = 32;
   localparam int AW = 16;
   localparam int NB = WW / DW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW-1:0] num_outputs = '0;
   logic          ready_write = 1'b0;
   logic [DW-1:0] ifm_output = '0;
   logic          busy, done, overflow, mem_wr_en;
   logic          mem_wr_ready = 1'b1;
   logic [AW-1:0] mem_addr;
   logic [WW-1:0] mem_wdata;
   logic [NB-1:0] mem_byte_en;

   always #5 clk = ~clk;

   pool_ofm_writer #(.DATA_WIDTH(DW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_outputs(num_outputs),
      .ready_write(ready_write), .ifm_output(ifm_output), .busy(busy), .done(done),
      .overflow(overflow), .mem_wr_en(mem_wr_en), .mem_wr_ready(mem_wr_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   logic [AW-1:0] wr_addr_q[$];
   logic [WW-1:0] wr_data_q[$];
   logic [NB-1:0] wr_be_q[$];
   int   done_cnt = 0;
   int   wren_cycles = 0;
   logic done_busy = 1'b1;

   // Transfer monitor, sampled between edges once inputs and outputs have settled.
   always @(negedge clk) begin
      #2;
      if (mem_wr_en) wren_cycles++;
      if (mem_wr_en && mem_wr_ready) begin
         wr_addr_q.push_back(mem_addr);
         wr_data_q.push_back(mem_wdata);
         wr_be_q.push_back(mem_byte_en);
         $display("write addr=0x%04h data=0x%08h be=0x%0h", mem_addr, mem_wdata, mem_byte_en);
      end
      if (done) begin
         done_cnt++;
         done_busy = busy;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic reset_logs();
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_be_q.delete();
      done_cnt = 0;
      wren_cycles = 0;
   endtask

   task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] n);
      @(negedge clk);
      start = 1'b1;
      base_addr = b;
      num_outputs = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input logic [DW-1:0] v);
      ready_write = 1'b1;
      ifm_output = v;
      @(negedge clk);
      ready_write = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      #3;
      check(tag, seen, 1);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_wr_en", mem_wr_en, 0);
      check("rst_overflow", overflow, 0);

      // Four-value layer
      reset_logs();
      do_start(16'h0010, 16'd4);
      check("t1_busy", busy, 1);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      wait_done("t1_done_seen");
      check("t1_nwrites", wr_data_q.size(), 1);
      check("t1_addr", wr_addr_q[0], 16'h0010);
      check("t1_data", wr_data_q[0], 32'h44332211);
      check("t1_be", wr_be_q[0], 4'hF);
      check("t1_busy_at_done", done_busy, 0);
      repeat (2) @(negedge clk);
      #3;
      check("t1_done_once", done_cnt, 1);

      // Partial last word
      reset_logs();
      do_start(16'h0020, 16'd6);
      for (int k = 1; k <= 6; k++) send(8'(k));
      wait_done("t2_done_seen");
      check("t2_nwrites", wr_data_q.size(), 2);
      check("t2_addr0", wr_addr_q[0], 16'h0020);
      check("t2_data0", wr_data_q[0], 32'h04030201);
      check("t2_be0", wr_be_q[0], 4'hF);
      check("t2_addr1", wr_addr_q[1], 16'h0021);
      check("t2_data1", wr_data_q[1], 32'h00000605);
      check("t2_be1", wr_be_q[1], 4'h3);

      // Backpressure and overflow
      reset_logs();
      mem_wr_ready = 1'b0;
      do_start(16'h0100, 16'd24);
      for (int k = 1; k <= 24; k++) send(8'(k));
      check("t3_overflow", overflow, 1);
      check("t3_wr_en", mem_wr_en, 1);
      check("t3_addr_stall", mem_addr, 16'h0100);
      check("t3_data_stall", mem_wdata, 32'h04030201);
      repeat (3) @(negedge clk);
      check("t3_addr_hold", mem_addr, 16'h0100);
      check("t3_data_hold", mem_wdata, 32'h04030201);
      check("t3_be_hold", mem_byte_en, 4'hF);
      check("t3_busy_stall", busy, 1);
      check("t3_no_writes", wr_data_q.size(), 0);
      mem_wr_ready = 1'b1;
      wait_done("t3_done_seen");
      check("t3_nwrites", wr_data_q.size(), 4);
      check("t3_addr3", wr_addr_q[3], 16'h0103);
      check("t3_data0", wr_data_q[0], 32'h04030201);
      check("t3_data1", wr_data_q[1], 32'h08070605);
      check("t3_data2", wr_data_q[2], 32'h0C0B0A09);
      check("t3_data3", wr_data_q[3], 32'h100F0E0D);
      @(negedge clk);
      check("t3_overflow_sticky", overflow, 1);

      // Ignored inputs: ready_write in IDLE, start while busy
      reset_logs();
      for (int k = 0; k < 3; k++) send(8'h55);
      do_start(16'h0300, 16'd2);
      check("t4_overflow_cleared", overflow, 0);
      send(8'hAA);
      start = 1'b1;
      base_addr = 16'h0400;
      num_outputs = 16'd1;
      send(8'hBB);
      start = 1'b0;
      wait_done("t4_done_seen");
      check("t4_nwrites", wr_data_q.size(), 1);
      check("t4_addr", wr_addr_q[0], 16'h0300);
      check("t4_data", wr_data_q[0], 32'h0000BBAA);
      check("t4_be", wr_be_q[0], 4'h3);

      // Zero-length layer
      repeat (2) @(negedge clk);
      reset_logs();
      do_start(16'h0800, 16'd0);
      check("t4z_done_early", done, 0);
      check("t4z_busy", busy, 1);
      @(negedge clk);
      check("t4z_done", done, 1);
      check("t4z_busy_low", busy, 0);
      repeat (3) @(negedge clk);
      #3;
      check("t4z_no_wr_en", wren_cycles, 0);
      check("t4z_done_once", done_cnt, 1);

      // Reset mid-layer with a word pending
      mem_wr_ready = 1'b0;
      do_start(16'h0500, 16'd8);
      for (int k = 1; k <= 5; k++) send(8'(k));
      check("t5_pending", mem_wr_en, 1);
      check("t5_pending_data", mem_wdata, 32'h04030201);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t5_busy", busy, 0);
      check("t5_done", done, 0);
      check("t5_overflow", overflow, 0);
      check("t5_wr_en", mem_wr_en, 0);
      check("t5_addr", mem_addr, 0);
      check("t5_wdata", mem_wdata, 0);
      check("t5_be", mem_byte_en, 0);
      reset_logs();
      mem_wr_ready = 1'b1;
      do_start(16'h0600, 16'd4);
      send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
      wait_done("t5_done_seen");
      check("t5_nwrites", wr_data_q.size(), 1);
      check("t5_new_addr", wr_addr_q[0], 16'h0600);
      check("t5_new_data", wr_data_q[0], 32'hA4A3A2A1);

      // Negative values
      reset_logs();
      do_start(16'h0700, 16'd4);
      send(8'h80); send(8'h7F); send(8'hFF); send(8'h01);
      wait_done("t6_done_seen");
      check("t6_nwrites", wr_data_q.size(), 1);
`ifdef OFM_RELU_EN
      check("t6_data", wr_data_q[0], 32'h01007F00);
`else
      check("t6_data", wr_data_q[0], 32'h01FF7F80);
`endif
      check("t6_be", wr_be_q[0], 4'hF);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
